photodiode_beam_detector: RTL and testbench



---
 rtl/photodiode_beam_detector.sv | 133 +++++++++++++
 tb/tb_photodiode_beam_detector.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/photodiode_beam_detector.sv
// Laser-harp photodiode front end: per-channel synchroniser and debouncer,
// plus a first-word-fall-through event queue of beam break/restore events.
module photodiode_beam_detector #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit INVERT          = 1'b1,
    parameter int FIFO_DEPTH      = 8,
    localparam int LVL_W          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       pd_in,
    output logic [7:0]       beam_state,
    output logic             evt_valid,
    output logic [3:0]       evt_data,
    input  logic             evt_ready,
    output logic             overflow,
    output logic [LVL_W-1:0] fifo_level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    logic [7:0]       sync1_q, sync2_q, s;
    logic [CNT_W-1:0] cnt_q [8];
    logic [CNT_W-1:0] cnt_d [8];
    logic [7:0]       beam_state_q, beam_state_d, flip;
    logic [7:0]       pend_q, pend_d, grant;
    logic             stage_vld_q, stage_vld_d;
    logic [3:0]       stage_word_q, stage_word_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             evt_valid_q, evt_valid_d;
    logic [3:0]       evt_data_q, evt_data_d;
    logic             overflow_q, overflow_d;
    logic [3:0]       mem_q [FIFO_DEPTH];
    logic             pop, wr, grant_ok;
    logic [2:0]       sel;

    always_comb begin
        s            = sync2_q ^ {8{INVERT}};
        beam_state_d = beam_state_q;
        flip         = '0;
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s[i] == beam_state_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                beam_state_d[i] = ~beam_state_q[i];
                cnt_d[i]        = '0;
                flip[i]         = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // A staging register sits between arbitration and the FIFO write; a new
    // grant is only issued when the staged word is guaranteed a slot.
    always_comb begin
        pop      = evt_valid_q && evt_ready;
        wr       = stage_vld_q && ((level_q != LVL_FULL) || pop);
        level_d  = level_q + LVL_W'(wr) - LVL_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(wr);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        grant_ok = (!stage_vld_q || wr) && ((level_d != LVL_FULL) || pop);

        sel = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pend_q[i]) sel = 3'(i);
        end

        grant        = '0;
        stage_vld_d  = stage_vld_q && !wr;
        stage_word_d = stage_word_q;
        if (grant_ok && (pend_q != '0)) begin
            grant[sel]   = 1'b1;
            stage_vld_d  = 1'b1;
            stage_word_d = {beam_state_q[sel], sel};
        end

        pend_d      = (pend_q & ~grant) | flip;
        overflow_d  = overflow_q || ((flip & pend_q & ~grant) != '0);
        evt_valid_d = (level_d != '0);
        evt_data_d  = (wr && (wr_ptr_q == rd_ptr_d)) ? stage_word_q : mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= {8{INVERT}};
            sync2_q      <= {8{INVERT}};
            for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
            beam_state_q <= '0;
            pend_q       <= '0;
            stage_vld_q  <= 1'b0;
            stage_word_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            evt_valid_q  <= 1'b0;
            evt_data_q   <= '0;
            overflow_q   <= 1'b0;
        end else begin
            sync1_q      <= pd_in;
            sync2_q      <= sync1_q;
            cnt_q        <= cnt_d;
            beam_state_q <= beam_state_d;
            pend_q       <= pend_d;
            stage_vld_q  <= stage_vld_d;
            stage_word_q <= stage_word_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            evt_valid_q  <= evt_valid_d;
            evt_data_q   <= evt_data_d;
            overflow_q   <= overflow_d;
        end
    end

    // NOTE: the queue storage has no reset; occupancy is tracked by the
    // pointers and level, so stale contents are never presented as valid.
    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= stage_word_q;
    end

    assign beam_state = beam_state_q;
    assign evt_valid  = evt_valid_q;
    assign evt_data   = evt_data_q;
    assign overflow   = overflow_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_photodiode_beam_detector.sv
// Bench for photodiode_beam_detector: a scoreboard queue of expected events,
// filled as pins are driven and drained as the DUT hands events over.
module tb_photodiode_beam_detector;

    localparam int DEB   = 4;
    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [7:0]       pd_in = 8'hFF;
    logic [7:0]       beam_state;
    logic             evt_valid;
    logic [3:0]       evt_data;
    logic             evt_ready = 1'b0;
    logic             overflow;
    logic [LVL_W-1:0] fifo_level;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    photodiode_beam_detector #(
        .DEBOUNCE_CYCLES(DEB),
        .INVERT         (1'b1),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pd_in     (pd_in),
        .beam_state(beam_state),
        .evt_valid (evt_valid),
        .evt_data  (evt_data),
        .evt_ready (evt_ready),
        .overflow  (overflow),
        .fifo_level(fifo_level)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag);
        int budget = 200;
        while ((exp_q.size() != 0 || evt_valid) && budget > 0) begin
            tick(1);
            budget--;
        end
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_valid"}, 32'(evt_valid), 32'd0);
        tick(4);
    endtask

    // Every handshake the DUT completes is matched against the scoreboard.
    always @(negedge clk) begin
        if (!reset && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) check("evt_unexpected", 32'(evt_data), 32'hDEAD);
            else                   check("evt", 32'(evt_data), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int max_lvl;

        // Reset with all beams intact
        tick(3);
        check("rst_beam", 32'(beam_state), 32'h0);
        check("rst_level", 32'(fifo_level), 32'h0);
        check("rst_data", 32'(evt_data), 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("rel_beam", 32'(beam_state), 32'h0);
            check("rel_valid", 32'(evt_valid), 32'h0);
            check("rel_ovf", 32'(overflow), 32'h0);
        end

        // Single pluck on string 3
        pd_in[3] = 1'b0;
        exp_q.push_back(4'hB);
        tick(5);
        check("pluck_beam_early", 32'(beam_state), 32'h00);
        tick(1);
        check("pluck_beam", 32'(beam_state), 32'h08);
        tick(1);
        check("pluck_valid_early", 32'(evt_valid), 32'h0);
        tick(1);
        check("pluck_valid", 32'(evt_valid), 32'h1);
        check("pluck_data", 32'(evt_data), 32'hB);
        check("pluck_level", 32'(fifo_level), 32'h1);
        evt_ready = 1'b1;
        tick(1);
        check("pluck_empty", 32'(fifo_level), 32'h0);
        pd_in[3] = 1'b1;
        exp_q.push_back(4'h3);
        wait_drain("release");
        check("release_beam", 32'(beam_state), 32'h00);

        // Glitch shorter than the debounce window
        pd_in[0] = 1'b0;
        tick(3);
        pd_in[0] = 1'b1;
        tick(12);
        check("glitch_beam", 32'(beam_state), 32'h00);
        check("glitch_valid", 32'(evt_valid), 32'h0);
        check("glitch_level", 32'(fifo_level), 32'h0);

        // Simultaneous breaks on 5, 1, 6
        evt_ready = 1'b0;
        pd_in = 8'h9D;
        exp_q.push_back(4'h9);
        exp_q.push_back(4'hD);
        exp_q.push_back(4'hE);
        max_lvl = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
        end
        check("simul_maxlvl", 32'(max_lvl), 32'd3);
        check("simul_beam", 32'(beam_state), 32'h62);
        evt_ready = 1'b1;
        tick(3);
        check("simul_drain3", 32'(fifo_level), 32'h0);
        pd_in = 8'hFF;
        exp_q.push_back(4'h1);
        exp_q.push_back(4'h5);
        exp_q.push_back(4'h6);
        wait_drain("simul");

        // Backpressure: six flips into a four-deep queue
        evt_ready = 1'b0;
        pd_in = 8'hC0;
        for (int ch = 0; ch < 6; ch++) exp_q.push_back({1'b1, 3'(ch)});
        tick(20);
        check("bp_level", 32'(fifo_level), 32'd4);
        check("bp_ovf", 32'(overflow), 32'h0);
        check("bp_head", 32'(evt_data), 32'h8);
        tick(5);
        check("bp_head_stable", 32'(evt_data), 32'h8);
        check("bp_valid_stable", 32'(evt_valid), 32'h1);
        evt_ready = 1'b1;
        wait_drain("bp");
        pd_in = 8'hFF;
        for (int ch = 0; ch < 6; ch++) exp_q.push_back({1'b0, 3'(ch)});
        wait_drain("bp_restore");
        check("bp_ovf_after", 32'(overflow), 32'h0);

        // Collapse: string 2 breaks and restores while the queue is full
        evt_ready = 1'b0;
        pd_in = 8'h0F;
        for (int ch = 4; ch < 8; ch++) exp_q.push_back({1'b1, 3'(ch)});
        tick(20);
        check("col_full", 32'(fifo_level), 32'd4);
        pd_in = 8'h0B;
        tick(10);
        pd_in = 8'h0F;
        tick(10);
        exp_q.push_back(4'h2);
        check("col_ovf", 32'(overflow), 32'h1);
        check("col_beam", 32'(beam_state), 32'hF0);
        check("col_level", 32'(fifo_level), 32'd4);
        evt_ready = 1'b1;
        wait_drain("col");
        check("col_ovf_sticky", 32'(overflow), 32'h1);

        // Reset with events queued
        evt_ready = 1'b0;
        pd_in = 8'hFF;
        tick(12);
        check("mid_level", 32'(fifo_level), 32'd4);
        reset = 1'b1;
        exp_q.delete();
        tick(1);
        check("mid_rst_beam", 32'(beam_state), 32'h0);
        check("mid_rst_valid", 32'(evt_valid), 32'h0);
        check("mid_rst_data", 32'(evt_data), 32'h0);
        check("mid_rst_ovf", 32'(overflow), 32'h0);
        check("mid_rst_level", 32'(fifo_level), 32'h0);
        tick(2);
        reset = 1'b0;
        tick(1);
        check("post_rst_valid", 32'(evt_valid), 32'h0);
        check("post_rst_beam", 32'(beam_state), 32'h0);
        tick(10);
        check("post_rst_quiet", 32'(fifo_level), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
